// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects
//   load-use hazards (ID vs EX), taken branches resolved in EX and data-memory
//   wait states. It drives the enable and bubble-insert controls of the PC,
//   IF/ID, ID/EX and EX/MEM registers. A small FSM (RUN / FLUSH / MEM_WAIT)
//   sequences multi-cycle flushes and memory freezes.
//
//   Parameters:
//     FLUSH_CYCLES  wrong-path flush cycles after a taken branch (1..15)
//     MAX_WAIT      consecutive mem_busy cycles that raise timeout_err (2..255)
//
//   Ports:
//     clk, reset          clock (rising edge), synchronous active-low reset
//     id_*                ID-stage instruction: valid, rs1/rs2, register-use flags
//     ex_rd, ex_mem_read  EX-stage destination register and load flag
//     ex_branch_taken     EX branch/jump resolved taken
//     mem_busy            data memory not ready
//     pc_en, if_id_en, id_ex_en, ex_mem_en   pipeline register enables
//     if_id_flush, id_ex_flush               bubble inserts
//     stall               any enable deasserted this cycle
//     state               FSM state (0 RUN, 1 FLUSH, 2 MEM_WAIT)
//     timeout_err         sticky memory-timeout flag
//     stall_cnt, flush_cnt, wait_cnt_tot     performance counters
//
//   Build option: define HAZ_PERF_CNT_EN to build the three 32-bit performance
//   counters. Without it, the counter ports are tied to zero.

module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_WAIT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        stall,
    output logic [1:0]  state,
    output logic        timeout_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] wait_cnt_tot
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] flush_rem_q, flush_rem_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic load_use;
    logic do_freeze;   // all four enables low
    logic do_flush;    // continue an outstanding wrong-path flush
    logic do_run;      // evaluate branch / load-use rules

    assign load_use = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        flush_rem_d = flush_rem_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        do_freeze   = 1'b0;
        do_flush    = 1'b0;
        do_run      = 1'b0;

        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    do_freeze  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    do_run = 1'b1;
                end
            end
            ST_FLUSH: begin
                // flush_rem is kept so the flush resumes after the freeze
                if (mem_busy) begin
                    do_freeze  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    do_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    do_freeze = 1'b1;
                    if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    // Release cycle: the deferred event is handled right away
                    wait_cnt_d = '0;
                    if (flush_rem_q != 4'd0) begin
                        do_flush = 1'b1;
                    end else begin
                        do_run = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (do_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end

        if (do_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_rem_d = flush_rem_q - 4'd1;
            state_d     = (flush_rem_q == 4'd1) ? ST_RUN : ST_FLUSH;
        end

        if (do_run) begin
            state_d = ST_RUN;
            if (ex_branch_taken) begin
                // The branch bubble also removes any load-use victim in ID
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_rem_d = FLUSH_INIT;
                end
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        if (!reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    assign stall       = reset & ~(pc_en & if_id_en & id_ex_en & ex_mem_en);
    assign state       = state_q;
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            flush_rem_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_rem_q <= flush_rem_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] wait_tot_q, wait_tot_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_tot_d  = wait_tot_q;
        if (load_use && state_q == ST_RUN) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_id_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (mem_busy && (state_q == ST_RUN || state_q == ST_MEM_WAIT)) begin
            wait_tot_d = wait_tot_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_tot_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_tot_q  <= wait_tot_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign wait_cnt_tot = wait_tot_q;
`else
    assign stall_cnt    = '0;
    assign flush_cnt    = '0;
    assign wait_cnt_tot = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share one stimulus
// stream: u0 (FLUSH_CYCLES=3, MAX_WAIT=4) and u1 (FLUSH_CYCLES=1, MAX_WAIT=64).
// A reference model tracks pending flush cycles, the busy streak length and
// the freeze status. It checks every cycle, first for directed scenarios and
// then for random traffic.

module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_mem_read, ex_branch_taken, mem_busy;

    logic        pc_en[2], if_id_en[2], if_id_flush[2], id_ex_en[2];
    logic        id_ex_flush[2], ex_mem_en[2], stall[2], timeout_err[2];
    logic [1:0]  state[2];
    logic [31:0] stall_cnt[2], flush_cnt[2], wait_cnt_tot[2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MAX_WAIT(4)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_en(id_ex_en[0]), .id_ex_flush(id_ex_flush[0]),
        .ex_mem_en(ex_mem_en[0]), .stall(stall[0]), .state(state[0]),
        .timeout_err(timeout_err[0]), .stall_cnt(stall_cnt[0]),
        .flush_cnt(flush_cnt[0]), .wait_cnt_tot(wait_cnt_tot[0])
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MAX_WAIT(64)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_en(id_ex_en[1]), .id_ex_flush(id_ex_flush[1]),
        .ex_mem_en(ex_mem_en[1]), .stall(stall[1]), .state(state[1]),
        .timeout_err(timeout_err[1]), .stall_cnt(stall_cnt[1]),
        .flush_cnt(flush_cnt[1]), .wait_cnt_tot(wait_cnt_tot[1])
    );

    // Reference model state, one slot per instance
    int unsigned fc[2] = '{3, 1};
    int unsigned mw[2] = '{4, 64};
    int unsigned rem[2];
    int unsigned streak[2];
    bit          frozen[2];
    bit          tout[2];
    logic [31:0] m_stall[2], m_flush[2], m_wait[2];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hazard();
        return id_valid && ex_mem_read && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) ||
                (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic int unsigned model_state(input int k);
        if (frozen[k]) return 2;
        if (rem[k] != 0) return 1;
        return 0;
    endfunction

    // Expected {pc,if_id,if_id_fl,id_ex,id_ex_fl,ex_mem,stall,state,timeout}
    function automatic logic [9:0] model_out(input int k);
        logic [5:0] ctl;   // pc, if_id, if_id_fl, id_ex, id_ex_fl, ex_mem
        logic       stl;
        if (!reset)                                    ctl = 6'b000000;
        else if (mem_busy)                             ctl = 6'b000000;
        else if (rem[k] != 0 || ex_branch_taken)       ctl = 6'b111111;
        else if (hazard())                             ctl = 6'b000111;
        else                                           ctl = 6'b110101;
        stl = reset && !(ctl[5] && ctl[4] && ctl[2] && ctl[0]);
        return {ctl, stl, 2'(model_state(k)), tout[k]};
    endfunction

    task automatic model_step(input int k);
        int unsigned st;
        st = model_state(k);
        if (!reset) begin
            rem[k] = 0; streak[k] = 0; frozen[k] = 0; tout[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 0;
            return;
        end
        if (hazard() && st == 0) m_stall[k] += 1;
        if (!mem_busy && (rem[k] != 0 || ex_branch_taken)) m_flush[k] += 1;
        if (mem_busy && st != 1) m_wait[k] += 1;
        if (mem_busy) begin
            if (streak[k] < 255) streak[k] += 1;
            frozen[k] = 1;
            if (streak[k] >= mw[k]) tout[k] = 1;
        end else begin
            streak[k] = 0;
            frozen[k] = 0;
            if (rem[k] != 0) rem[k] -= 1;
            else if (ex_branch_taken) rem[k] = fc[k] - 1;
        end
    endtask

    task automatic run_cycle();
        logic [31:0] e_st, e_fl, e_wt;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq(k == 0 ? "u0_ctl" : "u1_ctl",
                     32'({pc_en[k], if_id_en[k], if_id_flush[k], id_ex_en[k],
                          id_ex_flush[k], ex_mem_en[k], stall[k], state[k],
                          timeout_err[k]}),
                     32'(model_out(k)));
`ifdef HAZ_PERF_CNT_EN
            e_st = m_stall[k]; e_fl = m_flush[k]; e_wt = m_wait[k];
`else
            e_st = 0; e_fl = 0; e_wt = 0;
`endif
            check_eq(k == 0 ? "u0_stall_cnt" : "u1_stall_cnt", stall_cnt[k], e_st);
            check_eq(k == 0 ? "u0_flush_cnt" : "u1_flush_cnt", flush_cnt[k], e_fl);
            check_eq(k == 0 ? "u0_wait_tot" : "u1_wait_tot", wait_cnt_tot[k], e_wt);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
        ex_mem_read = 1'b1; ex_rd = rd;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    int unsigned busy_left = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; streak[k] = 0; frozen[k] = 0; tout[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 0;
        end
        set_idle();
        reset = 1'b0;
        run_cycle(); run_cycle();
        idle_cycles(1);

        // Load-use stall, then the same pattern against x0
        set_lu(5'd5); run_cycle();
        set_lu(5'd0); run_cycle();
        idle_cycles(1);

        // Branch pulse followed by load-use during the flush
        ex_branch_taken = 1'b1; run_cycle();
        set_idle(); set_lu(5'd5); run_cycle(); run_cycle();
        idle_cycles(2);

        // Four-cycle memory freeze
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle();
        idle_cycles(2);

        // Freeze starting on the second flush cycle
        ex_branch_taken = 1'b1; run_cycle();
        set_idle(); mem_busy = 1'b1; run_cycle(); run_cycle();
        idle_cycles(4);

        // Timeout: six busy cycles, then reset clears it
        mem_busy = 1'b1;
        for (int i = 0; i < 6; i++) run_cycle();
        idle_cycles(2);
        check_eq("timeout_sticky", 32'(timeout_err[0]), 32'd1);
        reset = 1'b0; run_cycle();
        idle_cycles(1);
        check_eq("timeout_cleared", 32'(timeout_err[0]), 32'd0);

        // Perf counter scenario on the FLUSH_CYCLES=1 instance
        reset = 1'b0; run_cycle();
        set_idle();
        set_lu(5'd5); run_cycle(); run_cycle();
        set_idle(); ex_branch_taken = 1'b1; run_cycle();
        set_idle(); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        idle_cycles(2);
`ifdef HAZ_PERF_CNT_EN
        check_eq("perf_stall", stall_cnt[1], 32'd2);
        check_eq("perf_flush", flush_cnt[1], 32'd1);
        check_eq("perf_wait", wait_cnt_tot[1], 32'd3);
`else
        check_eq("perf_stall", stall_cnt[1], 32'd0);
        check_eq("perf_flush", flush_cnt[1], 32'd0);
        check_eq("perf_wait", wait_cnt_tot[1], 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 99) != 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom);
            id_uses_rs2     = 1'($urandom);
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            if (busy_left == 0 && $urandom_range(0, 7) == 0)
                busy_left = $urandom_range(1, 7);
            mem_busy = (busy_left != 0);
            if (busy_left != 0) busy_left--;
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the enables and bubble-insert (flush) controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects three hazards:
  - load-use hazards between the ID and EX stages;
  - taken branches resolved in EX;
  - data-memory wait states.
- Sequences the multi-cycle flush and wait recovery through a small FSM.

Parameters:
- FLUSH_CYCLES, 1: cycles of wrong-path flush after a taken branch, 1..15; more than 1 models fetch latency.
- MAX_WAIT, 64: number of consecutive mem_busy cycles that raises timeout_err, 2..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  EX destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX branch/jump resolved taken.
- mem_busy  in  1  data memory not ready; pipeline must freeze.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID load NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX load bubble (control fields zeroed).
- ex_mem_en  out  1  EX/MEM load enable.
- stall  out  1  any enable deasserted this cycle.
- state  out  2  FSM state: 0 = RUN, 1 = FLUSH, 2 = MEM_WAIT.
- timeout_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  32  load-use stall cycles (see Optional Feature).
- flush_cnt  out  32  branch flush cycles (see Optional Feature).
- wait_cnt_tot  out  32  memory wait cycles (see Optional Feature).

Behaviour:
- **Outputs are combinational from state, counters and inputs.** Hazard response applies in the same cycle the hazard is visible.
- **During reset (reset = 0):**
  - all enables 0, all flushes 0, stall 0;
  - on the clock edge: state becomes RUN, flush_rem = 0, wait_cnt = 0, timeout_err = 0, perf counters = 0.
  - Reset mid-FLUSH or mid-MEM_WAIT abandons the operation with no residue.
- **load_use** = id_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)). Register x0 never hazards.
- **Default (no event):** all enables 1, flushes 0.
- **RUN, priority high to low:**
  1. mem_busy: all four enables 0, flushes 0. Next state MEM_WAIT, wait_cnt = 1.
  2. ex_branch_taken:
     - pc_en = 1, if_id_en = 1, id_ex_en = 1, ex_mem_en = 1, if_id_flush = 1, id_ex_flush = 1.
     - If FLUSH_CYCLES > 1: next state FLUSH, flush_rem = FLUSH_CYCLES - 1. Otherwise stay in RUN.
  3. load_use: pc_en = 0, if_id_en = 0, id_ex_en = 1, id_ex_flush = 1, ex_mem_en = 1. Stay in RUN; the hazard clears once the load advances.
- **FLUSH:**
  - mem_busy: freeze exactly as in RUN rule 1. Next state MEM_WAIT; flush_rem is retained.
  - Otherwise:
    - all enables 1, if_id_flush = 1, id_ex_flush = 1;
    - flush_rem decrements, and the FSM goes to RUN when flush_rem reaches 0;
    - ex_branch_taken and load_use are ignored, because EX and ID hold bubbles.
- **MEM_WAIT:**
  - While mem_busy = 1: all enables 0.
  - wait_cnt increments, saturating at 255.
  - When wait_cnt == MAX_WAIT - 1 and mem_busy is still 1, timeout_err is set on that edge. It stays set until reset.
  - The cycle mem_busy = 0:
    - wait_cnt is cleared;
    - if flush_rem > 0, FLUSH behaviour applies this cycle and the FSM returns to FLUSH;
    - otherwise RUN rules 2–3 apply this cycle and the FSM goes to RUN.
- **Simultaneous events:**
  - Branch plus load-use: the branch wins; its bubble also clears the ID instruction.
  - mem_busy plus anything: the freeze wins, and the other event is re-evaluated once mem_busy drops.
- **stall** = ~(pc_en & if_id_en & id_ex_en & ex_mem_en).
- **state encoding:** 2'd3 is unreachable; if entered, the FSM recovers to RUN on the next edge.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- **Defined:**
  - stall_cnt increments on every cycle with load_use asserted in RUN.
  - flush_cnt increments on every cycle with if_id_flush = 1.
  - wait_cnt_tot increments on every cycle with mem_busy = 1 in RUN or MEM_WAIT.
  - All three counters are 32-bit, wrap modulo 2^32, and clear on reset.
- **Not defined:** the three ports remain but are tied to 0, and no counter flops are synthesized.

Test Plan:
- **Load-use stall:** ex_mem_read = 1, ex_rd = 5, id_valid = 1, id_uses_rs1 = 1, id_rs1 = 5 for one cycle -> pc_en = 0, if_id_en = 0, id_ex_flush = 1, stall = 1; state stays 0. Repeat with ex_rd = 0 -> no stall.
- **Branch flush, FLUSH_CYCLES = 3:** ex_branch_taken pulse -> if_id_flush = 1 for exactly 3 consecutive cycles, state sequence 0,1,1,0; a load_use presented during cycles 2–3 is ignored.
- **Memory freeze:** mem_busy high for 4 cycles -> all enables 0 for those 4 cycles, state 2; on the release cycle enables return to 1 and state goes to 0; timeout_err stays 0.
- **Freeze inside flush, FLUSH_CYCLES = 3:** mem_busy for 2 cycles starting on the 2nd flush cycle -> remaining flushes resume afterwards, for a total of 3 if_id_flush cycles.
- **Timeout:** MAX_WAIT = 4, mem_busy held for 6 cycles -> timeout_err rises after the 4th busy cycle and stays 1 after mem_busy drops; reset = 0 for one edge clears it and returns state to 0.
- **Perf counters with HAZ_PERF_CNT_EN:** 2 load-use stalls + 1 branch (FLUSH_CYCLES = 1) + 3 busy cycles -> stall_cnt = 2, flush_cnt = 1, wait_cnt_tot = 3. Without the macro, all three read 0.
